// File: rtl/cu_ifetch_seq_if.sv
// Handshake and result bundle between the control unit, memory and the
// instruction-fetch sequencer. The slave side is the sequencer itself.
interface cu_ifetch_seq_if #(
    parameter int IW  = 32,
    parameter int CUL = 36
);
    logic            start;
    logic            flush;
    logic            mem_ready;
    logic [IW-1:0]   mem_data;
    logic [IW-1:0]   IR;
    logic            ir_valid;
    logic            busy;
    logic            fault;
    logic [3:0]      NS;
    logic [2:0]      k_sel;
    logic [CUL:0]    controlWord;

    modport slave (
        input  start,
        input  flush,
        input  mem_ready,
        input  mem_data,
        output IR,
        output ir_valid,
        output busy,
        output fault,
        output NS,
        output k_sel,
        output controlWord
    );

    modport master (
        output start,
        output flush,
        output mem_ready,
        output mem_data,
        input  IR,
        input  ir_valid,
        input  busy,
        input  fault,
        input  NS,
        input  k_sel,
        input  controlWord
    );
endinterface

// File: rtl/cu_ifetch_seq.sv
// Multi-cycle instruction-fetch sequencer. Issues a fetch, waits on the
// memory ready handshake with a bounded wait count, latches the instruction
// and hands off to decode. A timeout parks the sequencer in a sticky fault
// state; flush aborts any fetch. Every output is a register so the control
// word, NS and busy drop to zero the instant reset asserts.
module cu_ifetch_seq #(
    parameter int CUL      = 36,
    parameter int IW       = 32,
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    cu_ifetch_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    // A zero WAIT_MAX means wait forever for memory.
    localparam bit                 TIMEOUT_EN = (WAIT_MAX != 0);
    localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

    // Moore decode of the datapath control word. The 36 defined field bits
    // sit at [35:0] with PC_FS in the two LSBs; everything above is zero.
    function automatic logic [CUL:0] cw_of(input state_t st);
        logic [1:0] mem_cs;
        logic [1:0] size;
        logic [1:0] data_tri_sel;
        logic [1:0] pc_fs;
        logic       add_tri_sel;
        logic       ir_load;
        mem_cs       = 2'b00;
        size         = 2'b00;
        data_tri_sel = 2'b00;
        pc_fs        = 2'b00;
        add_tri_sel  = 1'b0;
        ir_load      = 1'b0;
        case (st)
            ST_REQ, ST_WAIT: begin
                mem_cs       = 2'b10;
                size         = 2'b11;
                add_tri_sel  = 1'b1;
                data_tri_sel = 2'b11;
            end
            ST_LOAD: begin
                mem_cs       = 2'b10;
                size         = 2'b11;
                add_tri_sel  = 1'b1;
                data_tri_sel = 2'b11;
                ir_load      = 1'b1;
            end
            ST_DONE: begin
                pc_fs        = 2'b01;
            end
            default: begin
                pc_fs        = 2'b00;
            end
        endcase
        return {{(CUL-35){1'b0}},
                5'b00000, 5'b00000, 5'b00000, 5'b00000,  // FS, SA, SB, DA
                1'b0, 1'b0,                              // w_reg, C0
                mem_cs,
                1'b0, 1'b0,                              // B_Sel, mem_write_en
                ir_load,
                1'b0,                                    // status_load
                size,
                add_tri_sel,
                data_tri_sel,
                1'b0,                                    // PC_sel
                pc_fs};
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [IW-1:0]      hold_r;
    logic [IW-1:0]      hold_nx_s;
    logic [IW-1:0]      ir_r;
    logic [IW-1:0]      ir_nx_s;
    logic               ir_valid_r;
    logic               ir_valid_nx_s;
    logic               fault_r;
    logic               fault_nx_s;
    logic [CUL:0]       cw_r;
    logic [3:0]         ns_r;
    logic               busy_r;

    // Next-state and datapath-register update rules; flush overrides all.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        hold_nx_s     = hold_r;
        ir_nx_s       = ir_r;
        ir_valid_nx_s = ir_valid_r;
        fault_nx_s    = fault_r;
        if (bus.flush) begin
            state_nx_s    = ST_IDLE;
            cnt_nx_s      = '0;
            ir_valid_nx_s = 1'b0;
            fault_nx_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nx_s    = ST_REQ;
                        ir_valid_nx_s = 1'b0;
                        cnt_nx_s      = '0;
                    end else begin
                        state_nx_s    = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ready) begin
                        hold_nx_s  = bus.mem_data;
                        state_nx_s = ST_LOAD;
                    end else begin
                        cnt_nx_s   = '0;
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_ready) begin
                        hold_nx_s  = bus.mem_data;
                        state_nx_s = ST_LOAD;
                    end else if (TIMEOUT_EN && (cnt_r == WAIT_LAST)) begin
                        state_nx_s = ST_FAULT;
                        fault_nx_s = 1'b1;
                    end else begin
                        cnt_nx_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    ir_nx_s       = hold_r;
                    ir_valid_nx_s = 1'b1;
                    state_nx_s    = ST_DONE;
                end
                ST_DONE: begin
                    state_nx_s = ST_IDLE;
                end
                ST_FAULT: begin
                    state_nx_s = ST_FAULT;
                    fault_nx_s = 1'b1;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath registers and outputs pre-decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            hold_r     <= '0;
            ir_r       <= '0;
            ir_valid_r <= 1'b0;
            fault_r    <= 1'b0;
            cw_r       <= '0;
            ns_r       <= 4'b0000;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            hold_r     <= hold_nx_s;
            ir_r       <= ir_nx_s;
            ir_valid_r <= ir_valid_nx_s;
            fault_r    <= fault_nx_s;
            cw_r       <= cw_of(state_nx_s);
            ns_r       <= (state_nx_s == ST_DONE) ? 4'b0001 : 4'b0000;
            busy_r     <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_FAULT);
        end
    end

    assign bus.IR          = ir_r;
    assign bus.ir_valid    = ir_valid_r;
    assign bus.fault       = fault_r;
    assign bus.controlWord = cw_r;
    assign bus.NS          = ns_r;
    assign bus.busy        = busy_r;
    assign bus.k_sel       = 3'b000;

endmodule

// File: tb/tb_cu_ifetch_seq.sv
// Self-checking bench for cu_ifetch_seq: randomized fetch scenarios compared
// cycle by cycle against a timeline computed from the fetch rules.
module tb_cu_ifetch_seq;

    localparam int WM  = 4;
    localparam int CUL = 36;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [31:0] ir_m;

    cu_ifetch_seq_if #(.IW(32), .CUL(CUL)) bus ();

    cu_ifetch_seq #(.CUL(CUL), .IW(32), .WAIT_MAX(WM), .CNT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word built field by field from the documented packing.
    function automatic logic [CUL:0] word(input logic [1:0] mem_cs, input logic [1:0] size,
                                          input logic add_t, input logic [1:0] data_t,
                                          input logic ir_load, input logic [1:0] pc_fs);
        logic [35:0] w;
        w = {20'd0, 1'b0, 1'b0, mem_cs, 1'b0, 1'b0, ir_load, 1'b0, size, add_t, data_t, 1'b0, pc_fs};
        return {1'b0, w};
    endfunction

    // One fetch. w = cycles with mem_ready low before it rises (w > WM times out),
    // fa = cycle index (1 = first cycle after the start edge) in which flush is
    // driven (0 = none), noise = stray start/mem_ready pulses where they must be ignored.
    task automatic run_fetch(input int w, input logic [31:0] d, input int fa, input bit noise);
        int r, last, fai;
        bit to;
        logic [CUL:0] e_cw, w_fetch, w_load, w_done;
        logic [3:0]   e_ns;
        logic         e_busy, e_flt, e_irv;
        logic [31:0]  e_ir, ir_prev;
        w_fetch = word(2'b10, 2'b11, 1'b1, 2'b11, 1'b0, 2'b00);
        w_load  = word(2'b10, 2'b11, 1'b1, 2'b11, 1'b1, 2'b00);
        w_done  = word(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01);
        to  = (w > WM);
        r   = w + 1;
        fai = fa;
        if (to && fai == 0) fai = WM + 4;
        last    = (fai > 0) ? fai + 1 : r + 3;
        ir_prev = ir_m;
        bus.start = 1'b1; bus.flush = 1'b0; bus.mem_ready = 1'b0; bus.mem_data = $urandom;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            e_ns = 4'b0000; e_flt = 1'b0; e_irv = 1'b0; e_ir = ir_prev;
            if (fai > 0 && k == fai + 1) begin
                e_cw = '0; e_busy = 1'b0;
                if (!to && fai >= r + 2) e_ir = d;
            end else if (to && k >= WM + 2) begin
                e_cw = '0; e_busy = 1'b0; e_flt = 1'b1;
            end else if (to || k <= r) begin
                e_cw = w_fetch; e_busy = 1'b1;
            end else if (k == r + 1) begin
                e_cw = w_load; e_busy = 1'b1;
            end else if (k == r + 2) begin
                e_cw = w_done; e_busy = 1'b1; e_ns = 4'b0001; e_ir = d; e_irv = 1'b1;
            end else begin
                e_cw = '0; e_busy = 1'b0; e_ir = d; e_irv = 1'b1;
            end
            checks += 6;
            if (bus.controlWord !== e_cw) begin errors++; $display("FAIL cw w=%0d fa=%0d k=%0d got=%h exp=%h", w, fai, k, bus.controlWord, e_cw); end
            if (bus.NS !== e_ns) begin errors++; $display("FAIL ns w=%0d fa=%0d k=%0d got=%b exp=%b", w, fai, k, bus.NS, e_ns); end
            if (bus.busy !== e_busy) begin errors++; $display("FAIL busy w=%0d fa=%0d k=%0d got=%b exp=%b", w, fai, k, bus.busy, e_busy); end
            if (bus.fault !== e_flt) begin errors++; $display("FAIL fault w=%0d fa=%0d k=%0d got=%b exp=%b", w, fai, k, bus.fault, e_flt); end
            if (bus.ir_valid !== e_irv) begin errors++; $display("FAIL ir_valid w=%0d fa=%0d k=%0d got=%b exp=%b", w, fai, k, bus.ir_valid, e_irv); end
            if (bus.IR !== e_ir) begin errors++; $display("FAIL ir w=%0d fa=%0d k=%0d got=%h exp=%h", w, fai, k, bus.IR, e_ir); end
            // Inputs for cycle k, sampled at the next rising edge.
            bus.start = (noise && k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.flush = (k == fai);
            if (to) bus.mem_ready = (k >= WM + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            else    bus.mem_ready = (k == r) ? 1'b1 : ((k < r) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (k == fai) bus.mem_ready = 1'b1;
            bus.mem_data = (!to && k == r) ? d : $urandom;
            if (k == last) ir_m = e_ir;
        end
        bus.start = 1'b0; bus.flush = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.mem_ready = 1'b0; bus.mem_data = '0;
        reset_n = 1'b0;
        #23 reset_n = 1'b1;
        ir_m = '0;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (bus.IR !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", bus.IR); end
        if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_irv got=%b exp=0", bus.ir_valid); end
        if (bus.controlWord !== '0) begin errors++; $display("FAIL reset_cw got=%h exp=0", bus.controlWord); end
        if (bus.NS !== 4'b0000) begin errors++; $display("FAIL reset_ns got=%b exp=0", bus.NS); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
        if (bus.k_sel !== 3'b000) begin errors++; $display("FAIL reset_ksel got=%b exp=0", bus.k_sel); end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_zero_wait();
        run_fetch(0, 32'hF8000FE1, 0, 1'b0);
    endtask

    task automatic test_three_waits();
        run_fetch(3, 32'h8B020020, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_fetch(WM + 1, $urandom, 0, 1'b1);
        run_fetch(WM, $urandom, 0, 1'b0);
    endtask

    task automatic test_flush_mid_wait();
        run_fetch(5, 32'h12345678, 0, 1'b0);
        run_fetch(4, $urandom, 3, 1'b0);
        run_fetch(1, $urandom, 3, 1'b0);
        run_fetch(0, $urandom, 3, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        logic [CUL:0] w_load;
        w_load = word(2'b10, 2'b11, 1'b1, 2'b11, 1'b1, 2'b00);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mem_ready = 1'b1; bus.mem_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        checks += 1;
        if (bus.controlWord !== w_load) begin errors++; $display("FAIL rst_load_cw got=%h exp=%h", bus.controlWord, w_load); end
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (bus.IR !== 32'h0) begin errors++; $display("FAIL rst_mid_ir got=%h exp=0", bus.IR); end
        if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_irv got=%b exp=0", bus.ir_valid); end
        if (bus.controlWord !== '0) begin errors++; $display("FAIL rst_mid_cw got=%h exp=0", bus.controlWord); end
        if (bus.NS !== 4'b0000) begin errors++; $display("FAIL rst_mid_ns got=%b exp=0", bus.NS); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        reset_n = 1'b1;
        ir_m = '0;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks += 3;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", bus.busy); end
            if (bus.controlWord !== '0) begin errors++; $display("FAIL post_rst_cw got=%h exp=0", bus.controlWord); end
            if (bus.IR !== 32'h0) begin errors++; $display("FAIL post_rst_ir got=%h exp=0", bus.IR); end
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_start_while_busy();
        run_fetch(2, $urandom, 0, 1'b1);
        run_fetch(0, $urandom, 0, 1'b1);
    endtask

    task automatic test_random();
        int w, fa;
        for (int i = 0; i < 40; i++) begin
            w  = $urandom_range(0, WM + 2);
            fa = 0;
            if ($urandom_range(0, 3) == 0) fa = $urandom_range(1, (w > WM) ? WM + 4 : w + 3);
            run_fetch(w, $urandom, fa, 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        test_reset();
        test_zero_wait();
        test_three_waits();
        test_timeout();
        test_flush_mid_wait();
        test_reset_mid_load();
        test_start_while_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
